// File: rtl/fpu_issue_arbiter.sv
// Two-requester FPU issue arbiter with credit-based response FIFOs and tag checking.
// Define FPU_ISSUE_ARBITER_FIXED_PRIORITY_EN to make requester 0 win every tie.
module fpu_issue_arbiter #(
    parameter int LATENCY = 4,
    parameter int CREDITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic        fpu_valid,
    output logic [3:0]  fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic        fpu_result_valid,
    input  logic [31:0] fpu_result,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [63:0] resp_data,
    output logic        err
);
    localparam logic [2:0] LP_CRED = 3'(CREDITS);
    localparam logic [1:0] LP_LAST = 2'(CREDITS - 1);

    logic [1:0]         w_elig;
    logic [1:0]         w_gnt;
    logic [1:0]         w_pop;
    logic [1:0]         w_push;
    logic               w_gid;
    logic               w_tail_v;
    logic               w_tail_id;

    logic [2:0]         r_credit [2];
    logic               r_fpu_valid;
    logic               r_fpu_id;
    logic [3:0]         r_fpu_op;
    logic [31:0]        r_fpu_a;
    logic [31:0]        r_fpu_b;
    logic [LATENCY-1:0] r_tag_v;
    logic [LATENCY-1:0] r_tag_id;
    logic [31:0]        r_mem [2][4];
    logic [1:0]         r_wp [2];
    logic [1:0]         r_rp [2];
    logic [2:0]         r_cnt [2];
    logic               r_err;

    always_comb begin
        w_elig = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_elig[i] = req_valid[i] && (r_credit[i] != 3'd0);
        end
    end

`ifdef FPU_ISSUE_ARBITER_FIXED_PRIORITY_EN
    always_comb begin
        w_gnt = 2'b00;
        if (w_elig[0]) begin
            w_gnt = 2'b01;
        end else if (w_elig[1]) begin
            w_gnt = 2'b10;
        end
    end
`else
    logic r_last;

    // On a tie, grant whichever requester was not granted last.
    always_comb begin
        w_gnt = w_elig;
        if (&w_elig) begin
            w_gnt = r_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (|w_gnt) begin
            r_last <= w_gnt[1];
        end
    end
`endif

    assign w_gid     = w_gnt[1];
    assign req_ready = w_gnt;

    assign w_tail_v  = r_tag_v[LATENCY-1];
    assign w_tail_id = r_tag_id[LATENCY-1];

    assign w_push[0] = fpu_result_valid & w_tail_v & ~w_tail_id;
    assign w_push[1] = fpu_result_valid & w_tail_v & w_tail_id;

    assign resp_valid[0] = (r_cnt[0] != 3'd0);
    assign resp_valid[1] = (r_cnt[1] != 3'd0);
    assign w_pop         = resp_valid & resp_ready;
    assign resp_data     = {r_mem[1][r_rp[1]], r_mem[0][r_rp[0]]};

    assign fpu_valid = r_fpu_valid;
    assign fpu_op    = r_fpu_op;
    assign fpu_a     = r_fpu_a;
    assign fpu_b     = r_fpu_b;
    assign err       = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fpu_valid <= 1'b0;
            r_fpu_id    <= 1'b0;
            r_fpu_op    <= 4'd0;
            r_fpu_a     <= 32'd0;
            r_fpu_b     <= 32'd0;
            r_tag_v     <= '0;
            r_tag_id    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_fpu_valid <= |w_gnt;
            if (|w_gnt) begin
                r_fpu_id <= w_gid;
                r_fpu_op <= w_gid ? req_op[7:4] : req_op[3:0];
                r_fpu_a  <= w_gid ? req_a[63:32] : req_a[31:0];
                r_fpu_b  <= w_gid ? req_b[63:32] : req_b[31:0];
            end
            // Tag pipe trails the issue register so the tail lines up with the result.
            r_tag_v[0]  <= r_fpu_valid;
            r_tag_id[0] <= r_fpu_id;
            for (int k = 1; k < LATENCY; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
            r_err <= r_err | (fpu_result_valid ^ w_tail_v);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_credit[i] <= LP_CRED;
                r_wp[i]     <= 2'd0;
                r_rp[i]     <= 2'd0;
                r_cnt[i]    <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) begin
                    r_wp[i] <= (r_wp[i] == LP_LAST) ? 2'd0 : r_wp[i] + 2'd1;
                end
                if (w_pop[i]) begin
                    r_rp[i] <= (r_rp[i] == LP_LAST) ? 2'd0 : r_rp[i] + 2'd1;
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 3'd1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 3'd1;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
                case ({w_gnt[i], w_pop[i]})
                    2'b10:   r_credit[i] <= r_credit[i] - 3'd1;
                    2'b01:   r_credit[i] <= r_credit[i] + 3'd1;
                    default: r_credit[i] <= r_credit[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wp[i]] <= fpu_result;
            end
        end
    end

endmodule

// File: doc/fpu_issue_arbiter.md
FPU_ISSUE_ARBITER -- requirements
Module: fpu_issue_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 4: FPU issue-to-result latency in cycles (fixed, no stall).
REQ-002 SHALL have parameter CREDITS, default 2: response-buffer depth per requester (1..4).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-006 SHALL have port req_ready  output  2  per-requester accept; combinational grant.
REQ-007 SHALL have port req_op  input  8  two packed 4-bit opcodes, [4i+3:4i].
REQ-008 SHALL have port req_a  input  64  two packed 32-bit operand A, [32i+31:32i].
REQ-009 SHALL have port req_b  input  64  two packed 32-bit operand B.
REQ-010 SHALL have port fpu_valid  output  1  registered issue strobe to FPU pipeline.
REQ-011 SHALL have ports fpu_op/fpu_a/fpu_b  output  4/32/32  registered issued operation.
REQ-012 SHALL have port fpu_result_valid  input  1  FPU result strobe.
REQ-013 SHALL have port fpu_result  input  32  FPU result word.
REQ-014 SHALL have port resp_valid  output  2  per-requester response available.
REQ-015 SHALL have port resp_ready  input  2  per-requester response consumed.
REQ-016 SHALL have port resp_data  output  64  two packed 32-bit responses.
REQ-017 SHALL have port err  output  1  sticky tag/result mismatch flag.

Function
REQ-018 SHALL grant at most one requester per cycle; requester i eligible iff req_valid[i] and credit[i] > 0.
REQ-019 SHALL arbitrate round-robin: both eligible -> grant the requester not equal to last-granted pointer; pointer updates only on a grant.
REQ-020 SHALL register a granted request into fpu_valid/fpu_op/fpu_a/fpu_b one cycle after handshake (handshake cycle N -> fpu_valid=1 in N+1); fpu_valid=0 in cycles with no grant.
REQ-021 SHALL push {valid, id} into a LATENCY-deep tag shift register alongside fpu_valid; shift every cycle.
REQ-022 SHALL, on fpu_result_valid with a valid tail tag, write fpu_result into response FIFO of tag id; resp_valid asserts the following cycle.
REQ-023 SHALL keep per-requester response FIFOs of depth CREDITS, first-word-fall-through, pop on resp_valid & resp_ready.
REQ-024 SHALL decrement credit[i] on grant to i, increment on pop from FIFO i; both same cycle -> unchanged; credit never exceeds CREDITS nor goes below 0.
REQ-025 SHALL never overflow a response FIFO (guaranteed by credits); credit[i]=0 forces req_ready[i]=0.
REQ-026 SHALL set err on fpu_result_valid with invalid tail tag, or valid tail tag without fpu_result_valid; result in the former case is dropped; err clears only on reset.
REQ-027 SHALL preserve per-requester response order equal to issue order.

Reset
REQ-028 SHALL on reset (any time, mid-operation included) clear: fpu_valid=0, fpu_op/fpu_a/fpu_b=0, all tags invalid, FIFOs empty, resp_valid=0, err=0, credit[i]=CREDITS, pointer=1 (requester 0 wins first tie); in-flight results are discarded.

Configuration
REQ-029 SHALL honour macro FPU_ISSUE_ARBITER_FIXED_PRIORITY_EN: defined -> requester 0 always wins ties, pointer unused; undefined -> round-robin per REQ-019.

Verification
REQ-030 Single req0 op=3, a=0x3F800000, b=0x40000000 at cycle 0 -> fpu_valid at 1, result injected at 5 -> resp_valid[0] at 6, resp_data[31:0]=injected value.
REQ-031 Both valid continuously, both resp_ready=1 -> grants alternate 0,1,0,1 (round-robin); with FIXED_PRIORITY_EN -> req0 wins every cycle until credit[0]=0, then req1 gets grant.
REQ-032 resp_ready[0]=0, req0 issues 2 ops -> req_ready[0]=0 from the third request; one pop -> req_ready[0]=1 the same cycle the credit returns.
REQ-033 Inject fpu_result_valid with empty tag pipe -> err=1 next cycle, no resp_valid; stays 1 until reset.
REQ-034 Assert reset with 3 ops in flight -> all outputs at reset values, credits=2 each, later stray fpu_result_valid sets err.
REQ-035 Simultaneous grant and pop on requester 1 at credit=1 -> credit stays 1, no lost response.
